frame_builder: RTL and testbench

FRAME_BUILDER -- requirements
Module: frame_builder

---
 rtl/frame_builder.sv | 173 +++++++++++++++++
 tb/tb_frame_builder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_builder.sv
// Response frame serializer: SOF, STATUS, CMD, optional read data, CRC8 toward a UART transmitter.
// All outputs are registered from the next-state values, so they change one cycle after the decision.
module frame_builder #(
    parameter logic [7:0] SOF_BYTE = 8'h2D,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       build_response,
    input  logic [7:0] cmd,
    input  logic [7:0] status,
    input  logic [7:0] read_data [0:63],
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       builder_busy,
    output logic       response_done
);

    localparam int unsigned DW = 8;
    localparam int unsigned NW = 7;
    localparam int unsigned AW = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_STAT,
        S_CMD,
        S_DATA,
        S_CRC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cmd_q, cmd_d;
    logic [DW-1:0]   status_q, status_d;
    logic [NW-1:0]   n_q, n_d;
    logic [NW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   crc_q, crc_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            xfer;

    // CRC8, polynomial 0x07, MSB first, one byte per call
    function automatic logic [DW-1:0] crc8_byte(input logic [DW-1:0] crc, input logic [DW-1:0] data);
        logic [DW-1:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Data byte count: only successful reads carry payload; size 11 carries none
    function automatic logic [NW-1:0] calc_n(input logic [DW-1:0] c, input logic [DW-1:0] s);
        logic [NW-1:0] beats;
        beats = NW'(c[3:0]) + NW'(1);
        if (!c[7] || (s != 8'h00)) return '0;
        case (c[5:4])
            2'b00:   return beats;
            2'b01:   return NW'(beats << 1);
            2'b10:   return NW'(beats << 2);
            default: return '0;
        endcase
    endfunction

    assign xfer = tx_valid_q & tx_ready;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        status_d   = status_q;
        n_d        = n_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (build_response) begin
                    cmd_d    = cmd;
                    status_d = status;
                    n_d      = calc_n(cmd, status);
                    idx_d    = '0;
                    crc_d    = CRC_INIT;
                    state_d  = S_SOF;
                end
            end
            S_SOF: begin
                if (xfer) state_d = S_STAT;
            end
            S_STAT: begin
                if (xfer) begin
                    crc_d   = crc8_byte(crc_q, tx_data_q);
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (xfer) begin
                    crc_d   = crc8_byte(crc_q, tx_data_q);
                    state_d = (n_q != '0) ? S_DATA : S_CRC;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    crc_d = crc8_byte(crc_q, tx_data_q);
                    if (idx_q == n_q - NW'(1)) state_d = S_CRC;
                    else                       idx_d   = idx_q + NW'(1);
                end
            end
            S_CRC: begin
                if (xfer) state_d = S_DONE;
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Output registers are loaded with what the upcoming state presents
        case (state_d)
            S_SOF:  tx_data_d = SOF_BYTE;
            S_STAT: tx_data_d = status_d;
            S_CMD:  tx_data_d = cmd_d;
            S_DATA: tx_data_d = read_data[idx_d[AW-1:0]];
            S_CRC:  tx_data_d = crc_d;
            default: tx_data_d = '0;
        endcase
        tx_valid_d = (state_d == S_SOF) || (state_d == S_STAT) || (state_d == S_CMD)
                  || (state_d == S_DATA) || (state_d == S_CRC);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            status_q   <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            crc_q      <= CRC_INIT;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            status_q   <= status_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign builder_busy  = busy_q;
    assign response_done = done_q;

endmodule

// File: tb/tb_frame_builder.sv
// Bench for frame_builder: expected frame bytes are queued at stimulus time and popped on each transfer.
module tb_frame_builder;

    logic       clk;
    logic       rst_n;
    logic       build_response;
    logic [7:0] cmd;
    logic [7:0] status;
    logic [7:0] rd [0:63];
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       builder_busy;
    logic       response_done;

    int checks;
    int errors;
    logic [7:0] q [$];

    frame_builder #(.SOF_BYTE(8'h2D), .CRC_INIT(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .build_response(build_response),
        .cmd           (cmd),
        .status        (status),
        .read_data     (rd),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .builder_busy  (builder_busy),
        .response_done (response_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial reference CRC8 (poly 0x07, MSB first)
    function automatic logic [7:0] crc_bits(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ b[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    task automatic push_model(input logic [7:0] c, input logic [7:0] s);
        int n;
        logic [7:0] crc;
        n = 0;
        if (c[7] && s == 8'h00) begin
            case (c[5:4])
                2'b00:   n = int'(c[3:0]) + 1;
                2'b01:   n = 2 * (int'(c[3:0]) + 1);
                2'b10:   n = 4 * (int'(c[3:0]) + 1);
                default: n = 0;
            endcase
        end
        q.push_back(8'h2D);
        q.push_back(s);
        q.push_back(c);
        crc = crc_bits(8'h00, s);
        crc = crc_bits(crc, c);
        for (int k = 0; k < n; k++) begin
            q.push_back(rd[k]);
            crc = crc_bits(crc, rd[k]);
        end
        q.push_back(crc);
    endtask

    // Pulse build_response for one cycle; the SOF byte must be presented right after
    task automatic start(input logic [7:0] c, input logic [7:0] s);
        build_response = 1'b1;
        cmd            = c;
        status         = s;
        @(posedge clk); #1;
        build_response = 1'b0;
        cmd            = 8'hFF;
        status         = 8'hFF;
        checks++;
        if (tx_valid !== 1'b1 || builder_busy !== 1'b1 || tx_data !== 8'h2D) begin
            errors++;
            $display("FAIL start_latency: valid=%b busy=%b data=%02h required valid=1 busy=1 data=2D",
                     tx_valid, builder_busy, tx_data);
        end
    endtask

    // Drain the scoreboard; optionally stall 3 cycles when byte number stall_a/stall_b is presented
    task automatic run_frame(input int stall_a, input int stall_b);
        int nx, stall, cyc, last_stall;
        bit fin, exp_done;
        logic [7:0] held, exp;
        nx = 0; stall = 0; cyc = 0; last_stall = -1; fin = 0; exp_done = 0; held = '0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (exp_done) begin
                checks++;
                if (response_done !== 1'b1 || tx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: done=%b valid=%b required done=1 valid=0", response_done, tx_valid);
                end
                fin = 1;
            end else if (stall > 0) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%02h required valid=1 data=%02h", tx_valid, tx_data, held);
                end
            end else if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte: got %02h required no byte", tx_data);
                end else begin
                    exp = q.pop_front();
                    if (tx_data !== exp) begin
                        errors++;
                        $display("FAIL frame_byte[%0d]: got %02h required %02h", nx, tx_data, exp);
                    end
                end
                nx++;
                if (q.size() == 0) exp_done = 1;
            end
            @(posedge clk); #1;
            build_response = 1'b0;
            if (stall > 0) begin
                stall--;
                if (stall == 0) tx_ready = 1'b1;
            end else if (!exp_done && (nx == stall_a || nx == stall_b) && nx != last_stall) begin
                last_stall     = nx;
                stall          = 3;
                tx_ready       = 1'b0;
                held           = tx_data;
                build_response = 1'b1;
                cmd            = 8'h81;
                status         = 8'h00;
            end
        end
        tx_ready = 1'b1;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: %0d bytes left in scoreboard, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || builder_busy !== 1'b0 || response_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: valid=%b data=%02h busy=%b done=%b required 0/00/0/0",
                     tx_valid, tx_data, builder_busy, response_done);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx_valid !== 1'b0 || builder_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b required 0/0", tx_valid, builder_busy);
        end
    endtask

    task automatic test_known_vectors();
        q.push_back(8'h2D); q.push_back(8'h00); q.push_back(8'h20); q.push_back(8'hE0);
        start(8'h20, 8'h00);
        run_frame(-1, -1);
        rd[0] = 8'hA5;
        q.push_back(8'h2D); q.push_back(8'h00); q.push_back(8'h80); q.push_back(8'hA5); q.push_back(8'hC4);
        start(8'h80, 8'h00);
        run_frame(-1, -1);
        q.push_back(8'h2D); q.push_back(8'h05); q.push_back(8'h80); q.push_back(8'hC8);
        start(8'h80, 8'h05);
        run_frame(-1, -1);
    endtask

    task automatic test_max_read();
        for (int k = 0; k < 64; k++) rd[k] = 8'(k);
        push_model(8'hAF, 8'h00);
        start(8'hAF, 8'h00);
        run_frame(-1, -1);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 64; k++) rd[k] = 8'($urandom_range(0, 255));
        push_model(8'h83, 8'h00);
        start(8'h83, 8'h00);
        run_frame(2, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b0 || builder_busy !== 1'b0) begin
                errors++;
                $display("FAIL ignored_request: valid=%b busy=%b required 0/0", tx_valid, builder_busy);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] cmds [0:4];
        logic [7:0] stats [0:4];
        cmds[0] = 8'hD2; stats[0] = 8'h00;
        cmds[1] = 8'hB5; stats[1] = 8'h00;
        cmds[2] = 8'h87; stats[2] = 8'h06;
        cmds[3] = 8'h43; stats[3] = 8'h04;
        cmds[4] = 8'h9F; stats[4] = 8'h00;
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 64; k++) rd[k] = 8'($urandom_range(0, 255));
            push_model(cmds[t], stats[t]);
            start(cmds[t], stats[t]);
            run_frame(-1, -1);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 64; k++) rd[k] = 8'($urandom_range(0, 255));
        start(8'h8F, 8'h00);
        repeat (6) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || builder_busy !== 1'b0 || response_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mid_frame: valid=%b data=%02h busy=%b done=%b required 0/00/0/0",
                     tx_valid, tx_data, builder_busy, response_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || builder_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_resume: valid=%b busy=%b required 0/0", tx_valid, builder_busy);
        end
        @(posedge clk); #1;
        push_model(8'h91, 8'h00);
        start(8'h91, 8'h00);
        run_frame(-1, -1);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b1;
        build_response = 1'b0;
        cmd            = 8'h00;
        status         = 8'h00;
        tx_ready       = 1'b1;
        for (int k = 0; k < 64; k++) rd[k] = 8'h00;

        test_reset();
        test_known_vectors();
        test_max_read();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
